// File: rtl/operand_collector_pkg.sv
// Shared constants and types for the operand collector: widths, operand
// slot indices and the collector state encoding.
package operand_collector_pkg;
  localparam int DATA_W  = 32;
  localparam int NUM_OPS = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] OP_A = 3'd0;
  localparam logic [IDX_W-1:0] OP_B = 3'd1;
  localparam logic [IDX_W-1:0] OP_C = 3'd2;
  localparam logic [IDX_W-1:0] OP_D = 3'd3;
  localparam logic [IDX_W-1:0] OP_E = 3'd4;
  localparam logic [IDX_W-1:0] OP_F = 3'd5;
  localparam logic [IDX_W-1:0] OP_G = 3'd6;
  localparam logic [IDX_W-1:0] OP_H = 3'd7;
endpackage

// File: rtl/operand_collector_bank.sv
// operand_bank: eight operand registers with indexed write and an optional
// clear of every slot above the written index (short-set zero fill).
module operand_bank #(
  parameter int DATA_W = operand_collector_pkg::DATA_W
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   we,
  input  logic                                                   zfill,
  input  logic [operand_collector_pkg::IDX_W-1:0]                widx,
  input  logic [DATA_W-1:0]                                      wdata,
  output logic [operand_collector_pkg::NUM_OPS-1:0][DATA_W-1:0]  ops
);
  import operand_collector_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (i == int'(widx))
          ops[i] <= wdata;
        else if (zfill && (i > int'(widx)))
          ops[i] <= '0;
      end
    end
  end
endmodule

// File: rtl/operand_collector.sv
// operand_collector: gathers eight operand words into a held bundle with
// valid/ready on both sides. OPERAND_COLLECTOR_PING_PONG_EN adds a second bank.
module operand_collector #(
  parameter int DATA_W = operand_collector_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_c,
  output logic [DATA_W-1:0] op_d,
  output logic [DATA_W-1:0] op_e,
  output logic [DATA_W-1:0] op_f,
  output logic [DATA_W-1:0] op_g,
  output logic [DATA_W-1:0] op_h,
  output logic              frame_err,
  output logic [CNT_W-1:0]  set_count
);
  import operand_collector_pkg::*;

  logic [IDX_W-1:0]                   idx;
  logic                               xfer, last_word, hs, zfill;
  logic [NUM_OPS-1:0][DATA_W-1:0]     ops;

  assign xfer      = in_valid && in_ready;
  assign last_word = xfer && ((idx == OP_H) || in_last);
  assign hs        = out_valid && out_ready;
  assign zfill     = xfer && in_last;

  // Shared control: word index, framing check and handoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      frame_err <= 1'b0;
      set_count <= '0;
    end else begin
      frame_err <= xfer && (idx == OP_H) && !in_last;
      if (hs)
        set_count <= set_count + 1'b1;
      if (last_word)
        idx <= '0;
      else if (xfer)
        idx <= idx + 1'b1;
    end
  end

`ifdef OPERAND_COLLECTOR_PING_PONG_EN
  logic [1:0]                         full, nfull;
  logic                               wr_sel, rd_sel, nwr, nrd;
  logic [NUM_OPS-1:0][DATA_W-1:0]     ops0, ops1;

  operand_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(xfer && !wr_sel), .zfill(zfill),
    .widx(idx), .wdata(in_data), .ops(ops0)
  );
  operand_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk(clk), .rst(rst), .we(xfer && wr_sel), .zfill(zfill),
    .widx(idx), .wdata(in_data), .ops(ops1)
  );

  // A handoff frees the read bank and a final word fills the write bank in
  // the same cycle; ready/valid are registered from the resulting occupancy.
  always_comb begin
    nfull = full;
    if (hs)
      nfull[rd_sel] = 1'b0;
    if (last_word)
      nfull[wr_sel] = 1'b1;
    nwr = wr_sel ^ last_word;
    nrd = rd_sel ^ hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      full      <= nfull;
      wr_sel    <= nwr;
      rd_sel    <= nrd;
      in_ready  <= !nfull[nwr];
      out_valid <= nfull[nrd];
    end
  end

  assign ops = rd_sel ? ops1 : ops0;
`else
  state_e state;

  operand_bank #(.DATA_W(DATA_W)) u_bank (
    .clk(clk), .rst(rst), .we(xfer), .zfill(zfill),
    .widx(idx), .wdata(in_data), .ops(ops)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          in_ready  <= !last_word;
          out_valid <= last_word;
          if (last_word)
            state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
`endif

  assign op_a = ops[OP_A];
  assign op_b = ops[OP_B];
  assign op_c = ops[OP_C];
  assign op_d = ops[OP_D];
  assign op_e = ops[OP_E];
  assign op_f = ops[OP_F];
  assign op_g = ops[OP_G];
  assign op_h = ops[OP_H];
endmodule
